// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the counter-width helper.
package serial_add_pkg;

  localparam int unsigned STATE_W = 2;

  // Code 3 is unused and falls back to S_IDLE in the controller.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = in_1 ^ in_2 ^ cin;
  assign count = (in_1 & in_2) | (in_1 & cin) | (in_2 & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one full_adder cell over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (result = op_a - op_b).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned         CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_sum_sr;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_sum;
  logic               w_count;
  logic [WIDTH-1:0]   w_sum_shift;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_cin_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as op_a + ~op_b + 1; cout=1 then means no borrow.
  assign w_b_load   = sub ? ~op_b : op_b;
  assign w_cin_load = sub ? 1'b1  : cin;
`else
  assign w_b_load   = op_b;
  assign w_cin_load = cin;
`endif

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_state == S_RUN) && (r_cnt == LAST_BIT);
  assign w_sum_shift = {w_sum, r_sum_sr};

  full_adder u_fa (
    .in_1  (r_a_sr[0]),
    .in_2  (r_b_sr[0]),
    .cin   (r_carry),
    .sum   (w_sum),
    .count (w_count)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start  ? S_RUN  : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start  ? S_RUN  : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Sum bits enter at the top of a WIDTH-1 bit register; the final bit
  // completes the word directly into the result register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr  <= op_a;
      r_b_sr  <= w_b_load;
      r_carry <= w_cin_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_shift[WIDTH-1:1];
      r_carry  <= w_count;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_sum_shift;
        r_cout   <= w_count;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule
